// File: rtl/clk_div_ctrl.sv
// Programmable integer clock divider with glitch-free ratio changes.
// The output is a posedge term ORed with a negedge term, which gives near-50% duty for odd ratios.
module clk_div_ctrl #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 9
) (
    input  logic             freq_src_clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             freq_new_clk,
    output logic             tick,
    output logic [CNT_W-1:0] div_active,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2,
        STOP = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pos_q, pos_d;
    logic             neg_q;
    logic             err_q, err_d;
    logic             tick_q, tick_d;

    logic             cfgXfer;
    logic             cfgLegal;
    logic             lastCount;
    logic [CNT_W-1:0] countNext;
    logic [CNT_W-1:0] halfDiv;

    assign cfg_ready = (state_q != PEND);
    assign cfgXfer   = cfg_valid && cfg_ready;
    assign cfgLegal  = (cfg_div >= TWO);
    // The wrap point always uses the active ratio, so a pending ratio cannot cut a period short.
    assign lastCount = (count_q == (div_q - ONE));
    assign countNext = lastCount ? '0 : (count_q + ONE);
    assign halfDiv   = div_q >> 1;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        div_d   = div_q;
        pend_d  = pend_q;
        err_d   = cfgXfer && !cfgLegal;
        pos_d   = (state_q != IDLE) && (count_q < halfDiv);
        tick_d  = (state_q != IDLE) && (count_q == '0);

        case (state_q)
            IDLE: begin
                count_d = '0;
                if (cfgXfer && cfgLegal) begin
                    div_d = cfg_div;
                end
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                count_d = countNext;
                if (cfgXfer && cfgLegal) begin
                    pend_d  = cfg_div;
                    state_d = PEND;
                end else if (!enable) begin
                    state_d = lastCount ? IDLE : STOP;
                end
            end
            PEND: begin
                count_d = countNext;
                // Switching the ratio on the wrap edge keeps every pulse full length.
                if (lastCount) begin
                    div_d   = pend_q;
                    state_d = enable ? RUN : IDLE;
                end
            end
            STOP: begin
                count_d = countNext;
                if (cfgXfer && cfgLegal) begin
                    pend_d  = cfg_div;
                    state_d = PEND;
                end else if (enable) begin
                    state_d = RUN;
                end else if (lastCount) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge freq_src_clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            div_q   <= CNT_W'(DEFAULT_DIV);
            pend_q  <= '0;
            pos_q   <= 1'b0;
            err_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
            pos_q   <= pos_d;
            err_q   <= err_d;
            tick_q  <= tick_d;
        end
    end

    // Half-cycle extension of the high phase, only for odd ratios.
    always_ff @(negedge freq_src_clk) begin
        if (reset) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q && div_q[0];
        end
    end

    assign freq_new_clk = pos_q | neg_q;
    assign cfg_err      = err_q;
    assign tick         = tick_q;
    assign div_active   = div_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: waveform shape, handshake, stop/restart and reset behaviour.
module tb_clk_div_ctrl;

    localparam int CNT_W = 8;

    logic             freq_src_clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic             freq_new_clk;
    logic             tick;
    logic [CNT_W-1:0] div_active;
    logic             busy;

    int errors = 0;
    int checks = 0;

    clk_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(9)) dut (
        .freq_src_clk(freq_src_clk),
        .reset       (reset),
        .enable      (enable),
        .cfg_valid   (cfg_valid),
        .cfg_div     (cfg_div),
        .cfg_ready   (cfg_ready),
        .cfg_err     (cfg_err),
        .freq_new_clk(freq_new_clk),
        .tick        (tick),
        .div_active  (div_active),
        .busy        (busy)
    );

    always #5 freq_src_clk = ~freq_src_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic en, input logic vld, input logic [CNT_W-1:0] div);
        reset     = rst;
        enable    = en;
        cfg_valid = vld;
        cfg_div   = div;
    endtask

    task automatic step();
        @(posedge freq_src_clk);
        #1;
    endtask

    task automatic halfStep();
        @(freq_src_clk);
        #1;
    endtask

    // Samples every half cycle: returns high half-cycles and rise-to-rise half-cycles.
    task automatic measureWave(output int hi, output int per);
        int guard;
        hi = 0;
        per = 0;
        guard = 0;
        while (freq_new_clk !== 1'b0 && guard < 1000) begin halfStep(); guard++; end
        while (freq_new_clk !== 1'b1 && guard < 1000) begin halfStep(); guard++; end
        while (freq_new_clk === 1'b1 && guard < 1000) begin hi++; per++; halfStep(); guard++; end
        while (freq_new_clk === 1'b0 && guard < 1000) begin per++; halfStep(); guard++; end
    endtask

    task automatic checkWave(input string tag, input int expHi, input int expPer);
        int hi, per;
        measureWave(hi, per);
        checkOutput({tag, "_high"}, hi, expHi);
        checkOutput({tag, "_period"}, per, expPer);
    endtask

    task automatic waitIdle(input string tag);
        int guard = 0;
        while (busy !== 1'b0 && guard < 600) begin step(); guard++; end
        checkOutput(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic waitDiv(input string tag, input logic [CNT_W-1:0] val);
        int guard = 0;
        while (div_active !== val && guard < 600) begin step(); guard++; end
        checkOutput(tag, div_active, val);
    endtask

    task automatic waitTick(input string tag);
        int guard = 0;
        while (tick !== 1'b1 && guard < 600) begin step(); guard++; end
        checkOutput(tag, {31'd0, tick}, 32'd1);
    endtask

    initial begin
        int gap;

        // Reset state
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
        repeat (3) step();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
        step();
        checkOutput("rst_ready", {31'd0, cfg_ready}, 32'd1);
        checkOutput("rst_div", div_active, 32'd9);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_out", {31'd0, freq_new_clk}, 32'd0);
        checkOutput("rst_tick", {31'd0, tick}, 32'd0);
        checkOutput("rst_err", {31'd0, cfg_err}, 32'd0);

        // Default ratio 9: high 4.5 cycles, period 9, tick every 9 cycles
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        step();
        checkOutput("run_busy", {31'd0, busy}, 32'd1);
        checkWave("n9", 9, 18);
        waitTick("n9_tick");
        step();
        gap = 1;
        while (tick !== 1'b1 && gap < 100) begin step(); gap++; end
        checkOutput("n9_tick_gap", gap, 32'd9);

        // Illegal ratios raise cfg_err and change nothing
        applyStimulus(1'b0, 1'b1, 1'b1, 8'd1);
        step();
        checkOutput("err1_pulse", {31'd0, cfg_err}, 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'd0);
        step();
        checkOutput("err0_pulse", {31'd0, cfg_err}, 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        step();
        checkOutput("err_clear", {31'd0, cfg_err}, 32'd0);
        checkOutput("err_div", div_active, 32'd9);
        checkWave("err_n9", 9, 18);

        // Ratio 4 loaded in IDLE
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
        waitIdle("stop_n9");
        checkOutput("idle_out", {31'd0, freq_new_clk}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd4);
        step();
        checkOutput("idle_div4", div_active, 32'd4);
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        checkWave("n4", 4, 8);

        // Ratio 6 running, change to 3 at count 2
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
        waitIdle("stop_n4");
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd6);
        step();
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        waitTick("n6_tick");
        step();
        applyStimulus(1'b0, 1'b1, 1'b1, 8'd3);
        step();
        checkOutput("pend_ready3", {31'd0, cfg_ready}, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        step();
        step();
        checkOutput("pend_ready5", {31'd0, cfg_ready}, 32'd0);
        checkOutput("pend_div_old", div_active, 32'd6);
        step();
        checkOutput("pend_ready_back", {31'd0, cfg_ready}, 32'd1);
        checkOutput("pend_div3", div_active, 32'd3);
        checkWave("n3", 3, 6);

        // Ratio 8, drop enable at count 1: period completes then IDLE
        applyStimulus(1'b0, 1'b1, 1'b1, 8'd8);
        step();
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        waitDiv("n8_div", 8'd8);
        step();
        checkOutput("n8_tick", {31'd0, tick}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
        repeat (6) step();
        checkOutput("stop_busy", {31'd0, busy}, 32'd1);
        step();
        checkOutput("stop_idle", {31'd0, busy}, 32'd0);
        checkOutput("stop_out", {31'd0, freq_new_clk}, 32'd0);

        // Re-raise enable during STOP: no gap before the next period
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        step();
        step();
        checkOutput("restart_tick", {31'd0, tick}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
        step();
        step();
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        gap = 0;
        while (tick !== 1'b1 && gap < 100) begin step(); gap++; end
        checkOutput("restart_gap", gap, 32'd6);
        checkWave("n8", 8, 16);

        // Reset mid high-phase with ratio 7 and a pending ratio
        applyStimulus(1'b0, 1'b1, 1'b1, 8'd7);
        step();
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        waitDiv("n7_div", 8'd7);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'd5);
        step();
        checkOutput("n7_high", {31'd0, freq_new_clk}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
        step();
        checkOutput("mrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("mrst_div", div_active, 32'd9);
        checkOutput("mrst_ready", {31'd0, cfg_ready}, 32'd1);
        @(negedge freq_src_clk);
        #1;
        checkOutput("mrst_out", {31'd0, freq_new_clk}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
        step();
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        checkWave("post_rst_n9", 9, 18);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
